pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_if.sv | 25 ++
 rtl/pipe_adder.sv | 109 ++++++++++
 tb/tb_pipe_adder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Handshake and data bundle for pipe_adder: operand side (in_*, a, b, cin)
// and result side (out_*, sum, cout).
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipe_adder.sv
// Chunked ripple-carry adder, one CHUNK-bit slice per registered stage, with
// valid/ready flow control. Define PIPE_ADDER_SAT_EN to saturate on overflow.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave io
);
  localparam int STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || WIDTH < 4 || STAGES < 1) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a multiple of CHUNK and at least 4");
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  // word holds finished sum chunks in the low part and untouched a chunks above
  logic [WIDTH-1:0]  word_q [STAGES];
  logic [WIDTH-1:0]  word_d [STAGES];
  // b is shifted right each stage so the next chunk to add is always at bit 0
  logic [WIDTH-1:0]  bsh_q  [STAGES];
  logic [WIDTH-1:0]  bsh_d  [STAGES];

  logic [STAGES:0]   accept;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_word [STAGES];
  logic [WIDTH-1:0]  src_b    [STAGES];

  // accept[k]: stage k may load this cycle (empty, or its content moves on)
  always_comb begin
    accept = '0;
    accept[STAGES] = io.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      accept[k] = !valid_q[k] || accept[k+1];
    end
  end

  always_comb begin
    src_word[0] = io.a;
    src_b[0]    = io.b;
    src_c[0]    = io.cin;
    src_v[0]    = io.in_valid && accept[0];
    for (int k = 1; k < STAGES; k++) begin
      src_word[k] = word_q[k-1];
      src_b[k]    = bsh_q[k-1];
      src_c[k]    = carry_q[k-1];
      src_v[k]    = valid_q[k-1];
    end
  end

  always_comb begin : datapath
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] nword;
    csum    = '0;
    nword   = '0;
    valid_d = valid_q;
    carry_d = carry_q;
    for (int k = 0; k < STAGES; k++) begin
      word_d[k] = word_q[k];
      bsh_d[k]  = bsh_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      csum = {1'b0, src_word[k][k*CHUNK +: CHUNK]}
           + {1'b0, src_b[k][CHUNK-1:0]}
           + {{CHUNK{1'b0}}, src_c[k]};
      nword = src_word[k];
      nword[k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
`ifdef PIPE_ADDER_SAT_EN
      if (k == STAGES - 1 && csum[CHUNK]) begin
        nword = '1;
      end
`endif
      if (accept[k]) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          word_d[k]  = nword;
          bsh_d[k]   = src_b[k] >> CHUNK;
          carry_d[k] = csum[CHUNK];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= '0;
        bsh_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= word_d[k];
        bsh_q[k]  <= bsh_d[k];
      end
    end
  end

  assign io.in_ready  = accept[0];
  assign io.out_valid = valid_q[STAGES-1];
  assign io.sum       = word_q[STAGES-1];
  assign io.cout      = carry_q[STAGES-1];
endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=16, CHUNK=4); expected
// values follow PIPE_ADDER_SAT_EN when it is defined.
module tb_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(16)) bus ();
  pipe_adder #(.WIDTH(16), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .io(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wait(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                           output int lat, output logic [15:0] s, output logic c);
    bus.a = ta; bus.b = tb_v; bus.cin = tc;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    s = bus.sum;
    c = bus.cout;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt, nin, nout, got, first, last;
    logic [15:0] s, held;
    logic        c, stall_prev;
    logic [15:0] sa [4];
    logic [15:0] sb [4];
    logic        sc [4];
    logic [16:0] se [4];
    logic [15:0] drain_exp [4];
    logic [15:0] ovf_sum;

    sa[0] = 16'h1234; sb[0] = 16'h4321; sc[0] = 1'b1;
    sa[1] = 16'h8000; sb[1] = 16'h8000; sc[1] = 1'b0;
    sa[2] = 16'hFFFF; sb[2] = 16'h0000; sc[2] = 1'b1;
    sa[3] = 16'h0F0F; sb[3] = 16'hF0F0; sc[3] = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
    se[0] = 17'h05556; se[1] = 17'h1FFFF; se[2] = 17'h1FFFF; se[3] = 17'h0FFFF;
    ovf_sum = 16'hFFFF;
`else
    se[0] = 17'h05556; se[1] = 17'h10000; se[2] = 17'h10000; se[3] = 17'h0FFFF;
    ovf_sum = 16'h0001;
`endif
    drain_exp[0] = 16'h2323; drain_exp[1] = 16'h3434;
    drain_exp[2] = 16'h4545; drain_exp[3] = 16'h5656;

    // reset with in_valid asserted
    rst = 1'b1; bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
    bus.cin = 1'b0; bus.out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    rst = 1'b0; bus.in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) cnt++;
      step();
    end
    check("rst_no_output", 32'(cnt), 32'd0);

    // carry ripple across all chunks
    send_wait(16'h0FFF, 16'h0001, 1'b0, lat, s, c);
    check("ripple_latency", 32'(lat), 32'd4);
    check("ripple_sum",     32'(s),   32'h1000);
    check("ripple_cout",    32'(c),   32'd0);

    // overflow
    send_wait(16'hFFFF, 16'h0001, 1'b1, lat, s, c);
    check("ovf_latency", 32'(lat), 32'd4);
    check("ovf_sum",     32'(s),   32'(ovf_sum));
    check("ovf_cout",    32'(c),   32'd1);

    // back-to-back stream, one result per cycle
    got = 0; first = -1; last = -1;
    for (int cy = 0; cy < 12; cy++) begin
      bus.out_ready = 1'b1;
      if (cy < 4) begin
        bus.in_valid = 1'b1; bus.a = sa[cy]; bus.b = sb[cy]; bus.cin = sc[cy];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        if (got < 4) check("stream_result", 32'({bus.cout, bus.sum}), 32'(se[got]));
        if (got == 0) first = cy;
        last = cy;
        got++;
      end
      step();
    end
    check("stream_count", 32'(got),   32'd4);
    check("stream_first", 32'(first), 32'd4);
    check("stream_last",  32'(last),  32'd7);

    // backpressure: out_ready low for cycles 3..8
    nin = 0; nout = 0; stall_prev = 1'b0; held = '0;
    for (int cy = 0; cy < 40 && nout < 6; cy++) begin
      bus.out_ready = !(cy >= 3 && cy <= 8);
      bus.in_valid  = (nin < 6);
      bus.a   = 16'(nin + 1);
      bus.b   = 16'(3 * (nin + 1));
      bus.cin = 1'b0;
      #1;
      if (cy == 4) check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && !bus.out_ready) begin
        if (stall_prev) check("bp_sum_hold", 32'(bus.sum), 32'(held));
        held = bus.sum;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("bp_order", 32'(bus.sum), 32'(4 * (nout + 1)));
        nout++;
      end
      if (bus.in_valid && bus.in_ready) nin++;
      if (cy == 8) check("bp_accepted_while_stalled", 32'(nin), 32'd4);
      step();
    end
    check("bp_delivered", 32'(nout), 32'd6);
    bus.in_valid = 1'b0;

    // bubbles collapse behind a stalled output
    bus.out_ready = 1'b0; nin = 0;
    for (int cy = 0; cy < 16; cy++) begin
      bus.in_valid = (nin < 5) && ((cy % 2 == 0) || nin >= 4);
      bus.a = 16'(nin + 1) * 16'h1111;
      bus.b = 16'h0101;
      bus.cin = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready) nin++;
      step();
    end
    check("bubble_accepted", 32'(nin),           32'd4);
    check("bubble_full",     32'(bus.in_ready),  32'd0);

    // simultaneous in and out transfer on a full pipeline
    bus.out_ready = 1'b1;
    #1;
    check("simul_out_valid", 32'(bus.out_valid), 32'd1);
    check("simul_in_ready",  32'(bus.in_ready),  32'd1);
    check("simul_sum",       32'(bus.sum),       32'h1212);
    step();
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("simul_still_full", 32'(bus.in_ready), 32'd0);
    check("simul_next_sum",   32'(bus.sum),      32'h2323);
    bus.out_ready = 1'b1;
    got = 0;
    for (int cy = 0; cy < 12 && got < 4; cy++) begin
      if (bus.out_valid) begin
        check("drain_order", 32'(bus.sum), 32'(drain_exp[got]));
        got++;
      end
      step();
    end
    check("drain_count", 32'(got), 32'd4);

    // reset with three entries in flight
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.a = 16'(i + 7); bus.b = 16'h0100; bus.cin = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) cnt++;
      step();
    end
    check("midrst_no_stale", 32'(cnt), 32'd0);
    send_wait(16'h0002, 16'h0003, 1'b0, lat, s, c);
    check("midrst_latency", 32'(lat), 32'd4);
    check("midrst_sum",     32'(s),   32'h0005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
